mpydiv9900: RTL and testbench



---
 rtl/mpydiv9900.sv | 254 +++++++++++++++++++++++++
 tb/tb_mpydiv9900.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mpydiv9900.sv
// mpydiv9900: sequential radix-2 multiply / restoring-divide unit for the
// TMS9900-compatible execute stage. MPY/DIV always; MPYS/DIVS and the
// ST0-ST2 flags only when MPYDIV_SIGNED_EN is defined.
module mpydiv9900 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] arg_a,
    input  logic [WIDTH-1:0] arg_b,
    input  logic [WIDTH-1:0] arg_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             overflow,
    output logic             st_lgt,
    output logic             st_agt,
    output logic             st_eq
);

`ifdef MPYDIV_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_MAG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;    // partial product high / partial remainder
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;    // multiplier bits / dividend bits -> quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;        // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               is_sgn_q, is_sgn_d;
    logic               neg_q, neg_d;          // negate product / quotient in FIX
    logic               rneg_q, rneg_d;        // negate remainder in FIX
    logic               sovf_q, sovf_d;        // signed quotient cannot fit WIDTH bits
    logic [WIDTH-1:0]   echo_b_q, echo_b_d;
    logic [WIDTH-1:0]   echo_c_q, echo_c_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               lgt_q, lgt_d;
    logic               agt_q, agt_d;
    logic               eq_q, eq_d;

    logic               sgn_sel, a_neg, b_neg, q_too_big;
    logic [WIDTH-1:0]   mag_a, mag_b, q_fix, r_fix;
    logic [2*WIDTH-1:0] mag_dvd, prod, prod_fix;
    logic [WIDTH:0]     mul_sum, div_part, div_diff;

    // Next-state, datapath iteration and sign fix-up
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        is_sgn_d = is_sgn_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        sovf_d   = sovf_q;
        echo_b_d = echo_b_q;
        echo_c_d = echo_c_q;
        busy_d   = busy_q;
        done_d   = done_q;
        ovf_d    = ovf_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        lgt_d    = lgt_q;
        agt_d    = agt_q;
        eq_d     = eq_q;

        // Magnitude conversion of the incoming operands (identity when unsigned)
        sgn_sel  = SIGNED_EN & op[1];
        a_neg    = sgn_sel & arg_a[WIDTH-1];
        b_neg    = sgn_sel & arg_b[WIDTH-1];
        mag_a    = a_neg ? (~arg_a + 1'b1) : arg_a;
        mag_b    = b_neg ? (~arg_b + 1'b1) : arg_b;
        mag_dvd  = b_neg ? (~{arg_b, arg_c} + 1'b1) : {arg_b, arg_c};

        // One shift-add step and one restoring-divide step
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_part = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_part - {1'b0, opnd_q};

        // Sign-corrected results
        prod      = {acc_hi_q, acc_lo_q};
        prod_fix  = neg_q ? (~prod + 1'b1) : prod;
        q_fix     = neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        r_fix     = rneg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        q_too_big = neg_q ? (acc_lo_q > MIN_MAG) : acc_lo_q[WIDTH-1];

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = op[0];
                    is_sgn_d = sgn_sel;
                    cnt_d    = '0;
                    opnd_d   = mag_a;
                    echo_b_d = arg_b;
                    echo_c_d = arg_c;
                    neg_d    = a_neg ^ b_neg;
                    if (op[0]) begin
                        acc_hi_d = mag_dvd[2*WIDTH-1:WIDTH];
                        acc_lo_d = mag_dvd[WIDTH-1:0];
                        rneg_d   = b_neg;
                        sovf_d   = sgn_sel & (mag_dvd[2*WIDTH-1:WIDTH] >= mag_a);
                    end else begin
                        acc_hi_d = '0;
                        acc_lo_d = mag_b;
                        rneg_d   = 1'b0;
                        sovf_d   = 1'b0;
                    end
                    if (op[0] && !sgn_sel && (arg_a <= arg_b)) begin
                        // Unsigned quotient cannot fit: report at once, D unchanged
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        ovf_d    = 1'b1;
                        res_hi_d = arg_b;
                        res_lo_d = arg_c;
                        lgt_d    = 1'b0;
                        agt_d    = 1'b0;
                        eq_d     = 1'b0;
                    end else begin
                        state_d  = S_CALC;
                        busy_d   = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_hi_d = div_diff[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_hi_d = div_part[WIDTH-1:0];
                        acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_hi_d = mul_sum[WIDTH:1];
                    acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                done_d  = 1'b1;
                ovf_d   = 1'b0;
                lgt_d   = 1'b0;
                agt_d   = 1'b0;
                eq_d    = 1'b0;
                if (!is_div_q) begin
                    res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    res_lo_d = prod_fix[WIDTH-1:0];
                    if (is_sgn_q) begin
                        eq_d  = (prod_fix == '0);
                        lgt_d = (prod_fix != '0);
                        agt_d = !prod_fix[2*WIDTH-1] && (prod_fix != '0);
                    end
                end else if (is_sgn_q && (sovf_q || q_too_big)) begin
                    ovf_d    = 1'b1;
                    res_hi_d = echo_b_q;
                    res_lo_d = echo_c_q;
                end else begin
                    res_hi_d = q_fix;
                    res_lo_d = r_fix;
                    if (is_sgn_q) begin
                        eq_d  = (q_fix == '0);
                        lgt_d = (q_fix != '0);
                        agt_d = !q_fix[WIDTH-1] && (q_fix != '0);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            is_sgn_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            sovf_q   <= 1'b0;
            echo_b_q <= '0;
            echo_c_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            lgt_q    <= 1'b0;
            agt_q    <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            is_sgn_q <= is_sgn_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            sovf_q   <= sovf_d;
            echo_b_q <= echo_b_d;
            echo_c_q <= echo_c_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            lgt_q    <= lgt_d;
            agt_q    <= agt_d;
            eq_q     <= eq_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign overflow  = ovf_q;
    assign st_lgt    = lgt_q;
    assign st_agt    = agt_q;
    assign st_eq     = eq_q;

endmodule

// File: tb/tb_mpydiv9900.sv
// Self-checking bench for mpydiv9900 (WIDTH=16): directed cases plus random
// operations compared against an arithmetic reference model.
module tb_mpydiv9900;
    localparam int W = 16;
`ifdef MPYDIV_SIGNED_EN
    localparam bit SEN = 1'b1;
`else
    localparam bit SEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] arg_a = '0, arg_b = '0, arg_c = '0;
    logic         busy, done, overflow, st_lgt, st_agt, st_eq;
    logic [W-1:0] result_hi, result_lo;

    int n_checks = 0;
    int n_fail   = 0;

    mpydiv9900 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .arg_a(arg_a), .arg_b(arg_b), .arg_c(arg_c),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .overflow(overflow), .st_lgt(st_lgt), .st_agt(st_agt), .st_eq(st_eq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the architectural values
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, b, c,
                         output logic [W-1:0] eh, el, output logic ov, lg, ag, eq,
                         output int lat);
        bit sg;
        logic [31:0] up, dvd;
        longint p, sd, sa, q, r;
        sg = o[1] && SEN;
        eh = '0; el = '0; ov = 1'b0; lg = 1'b0; ag = 1'b0; eq = 1'b0;
        lat = W + 1;
        if (!o[0]) begin
            if (!sg) begin
                up = 32'(a) * 32'(b);
                eh = up[31:16]; el = up[15:0];
            end else begin
                p = longint'($signed(a)) * longint'($signed(b));
                eh = p[31:16]; el = p[15:0];
                eq = (p == 0); lg = (p != 0); ag = (p > 0);
            end
        end else if (!sg) begin
            if (a <= b) begin
                ov = 1'b1; eh = b; el = c; lat = 0;
            end else begin
                dvd = {b, c};
                up = dvd / 32'(a); eh = up[15:0];
                up = dvd % 32'(a); el = up[15:0];
            end
        end else begin
            sd = longint'($signed({b, c}));
            sa = longint'($signed(a));
            if (sa == 0) begin
                ov = 1'b1; eh = b; el = c;
            end else begin
                q = sd / sa;
                r = sd % sa;
                if (q < -32768 || q > 32767) begin
                    ov = 1'b1; eh = b; el = c;
                end else begin
                    eh = q[15:0]; el = r[15:0];
                    eq = (q == 0); lg = (q != 0); ag = (q > 0);
                end
            end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, b, c, input bit inject);
        logic [W-1:0] eh, el;
        logic ov, lg, ag, eq;
        int lat, n;
        model(o, a, b, c, eh, el, ov, lg, ag, eq, lat);
        @(negedge clk);
        start = 1'b1; op = o; arg_a = a; arg_b = b; arg_c = c;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        check("busy_after_start", busy, (lat == 0) ? 1'b0 : 1'b1);
        while (done !== 1'b1 && n < 40) begin
            if (inject && n == 5) begin
                start = 1'b1; op = 2'($urandom);
                arg_a = W'($urandom); arg_b = W'($urandom); arg_c = W'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", n, lat);
        check("result_hi", result_hi, eh);
        check("result_lo", result_lo, el);
        check("overflow", overflow, ov);
        check("st_flags", {st_lgt, st_agt, st_eq}, {lg, ag, eq});
        $display("op=%b a=%h b=%h c=%h -> hi=%h lo=%h ovf=%b st=%b%b%b lat=%0d",
                 o, a, b, c, result_hi, result_lo, overflow, st_lgt, st_agt, st_eq, n);
        @(posedge clk); #1;
        check("done_one_cycle", {done, busy}, 2'b00);
        check("result_hold", {result_hi, result_lo}, {eh, el});
    endtask

    initial begin
        logic [1:0]   ro;
        logic [W-1:0] ra, rb, rc;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {busy, done, overflow, st_lgt, st_agt, st_eq}, 6'b0);
        check("reset_results", {result_hi, result_lo}, 32'h0);
        @(negedge clk); reset = 1'b0;

        // Directed cases
        run_op(2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0);
        run_op(2'b01, 16'h0002, 16'h0001, 16'h0000, 1'b0);
        run_op(2'b01, 16'h0001, 16'h0001, 16'h1234, 1'b0);
        run_op(2'b01, 16'h0000, 16'h0000, 16'h1234, 1'b0);
        run_op(2'b01, 16'hFFFF, 16'hFFFE, 16'hFFFF, 1'b0);
        run_op(2'b00, 16'h1234, 16'h5678, 16'h0000, 1'b1);
`ifdef MPYDIV_SIGNED_EN
        run_op(2'b11, 16'h0002, 16'hFFFF, 16'hFFF9, 1'b0);
        run_op(2'b10, 16'h8000, 16'h8000, 16'h0000, 1'b0);
        run_op(2'b11, 16'h0000, 16'h0000, 16'h0005, 1'b0);
        run_op(2'b11, 16'h0001, 16'hFFFF, 16'h8000, 1'b0);
        run_op(2'b11, 16'h0001, 16'h0000, 16'h8000, 1'b0);
        run_op(2'b10, 16'h0000, 16'h8123, 16'h0000, 1'b0);
`else
        run_op(2'b10, 16'hFFFF, 16'h0002, 16'h0000, 1'b0);
        run_op(2'b11, 16'h0003, 16'h0001, 16'h0007, 1'b0);
`endif

        // Reset in the middle of a divide
        @(negedge clk);
        start = 1'b1; op = 2'b01; arg_a = 16'h9000; arg_b = 16'h1234; arg_c = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_state", {busy, done, overflow, st_lgt, st_agt, st_eq}, 6'b0);
        check("abort_results", {result_hi, result_lo}, 32'h0);
        @(negedge clk); reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", {busy, done}, 2'b00);
        run_op(2'b01, 16'h9000, 16'h1234, 16'h5678, 1'b0);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            rc = W'($urandom);
            if (ro[0] && $urandom_range(0, 3) != 0) begin
                if (ro[1] && SEN) begin
                    rb = rc[W-1] ? 16'hFFFF : 16'h0000;
                end else if (ra != 0) begin
                    rb = rb % ra;
                end
            end
            run_op(ro, ra, rb, rc, (i % 7) == 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
